// File: rtl/deskew_ctrl_rx_if.sv
// Lane-side bundle for the deskew controller: per-lane AM status in, shared
// lock broadcast and skew measurement out.
interface deskew_ctrl_rx_if #(
   parameter int LANE_N = 4,
   parameter int WIN_W  = 5
);
   logic [LANE_N-1:0] am_lock_i;
   logic [LANE_N-1:0] am_v_i;
   logic [LANE_N-1:0] skew_zero_i;
   logic              am_lite_lock_full_v_o;
   logic              deskew_fail_o;
   logic [WIN_W-1:0]  skew_span_o;
   logic [LANE_N-1:0] latest_lane_o;

   modport master (
      output am_lock_i, am_v_i, skew_zero_i,
      input  am_lite_lock_full_v_o, deskew_fail_o, skew_span_o, latest_lane_o
   );

   modport slave (
      input  am_lock_i, am_v_i, skew_zero_i,
      output am_lite_lock_full_v_o, deskew_fail_o, skew_span_o, latest_lane_o
   );
endinterface

// File: rtl/deskew_ctrl_rx.sv
// Multi-lane deskew controller: measures the AM arrival span across lanes,
// freezes all lane read pointers once every AM is seen, re-verifies each period.
module deskew_ctrl_rx #(
   parameter int LANE_N           = 4,
   parameter int MAX_SKEW_BLOCK_N = 27,
   parameter int WIN_W            = $clog2(MAX_SKEW_BLOCK_N + 1)
) (
   input logic             clk,
   input logic             nreset,
   deskew_ctrl_rx_if.slave bus
);
   typedef enum logic [2:0] {IDLE, COLLECT, LOCKED, VERIFY, FAIL} state_t;

   localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(MAX_SKEW_BLOCK_N - 1);

   state_t            state_q, state_d;
   logic [LANE_N-1:0] mask_q, mask_d;
   logic [WIN_W-1:0]  win_q, win_d;
   logic [WIN_W-1:0]  span_q, span_d;
   logic [LANE_N-1:0] latest_q, latest_d;
   logic              lock_full_q;
   logic              fail_q;
   logic              coll_lock_q;

   logic              all_lock;
   logic [LANE_N-1:0] m;
   logic              dup;
   logic              full;
   logic [WIN_W-1:0]  limit;

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      win_d    = win_q;
      span_d   = span_q;
      latest_d = latest_q;
      all_lock = &bus.am_lock_i;
      m        = mask_q | bus.am_v_i;
      dup      = |(bus.am_v_i & mask_q);
      full     = &m;
      limit    = (state_q == COLLECT) ? WIN_MAX : span_q;

      case (state_q)
         IDLE: begin
            if (all_lock) state_d = COLLECT;
         end
         COLLECT, LOCKED, VERIFY: begin
            // LOCKED idles with mask/win at zero, so its first AM cycle is
            // evaluated exactly like the first AM cycle of a window.
            if (state_q != LOCKED || |bus.am_v_i) begin
               mask_d = m;
               win_d  = (|m) ? win_q + WIN_W'(1) : '0;
               if (dup) begin
                  state_d = FAIL;
               end else if (full) begin
                  if (state_q == COLLECT) begin
                     state_d  = LOCKED;
                     span_d   = win_q;
                     latest_d = bus.am_v_i;
                  end else begin
                     state_d = (win_q == span_q) ? LOCKED : FAIL;
                  end
                  mask_d = '0;
                  win_d  = '0;
               end else if (|m && win_q == limit) begin
                  state_d = FAIL;
               end else if (state_q == LOCKED) begin
                  state_d = VERIFY;
               end
            end
         end
         FAIL:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (!all_lock && (state_q == COLLECT || state_q == LOCKED || state_q == VERIFY))
         state_d = IDLE;

      if (state_d == IDLE) begin
         mask_d   = '0;
         win_d    = '0;
         span_d   = '0;
         latest_d = '0;
      end
   end

   // Outputs are registered from the next state so they move one cycle after the deciding AM.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q     <= IDLE;
         mask_q      <= '0;
         win_q       <= '0;
         span_q      <= '0;
         latest_q    <= '0;
         lock_full_q <= 1'b0;
         fail_q      <= 1'b0;
         coll_lock_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         win_q       <= win_d;
         span_q      <= span_d;
         latest_q    <= latest_d;
         lock_full_q <= (state_d == LOCKED) || (state_d == VERIFY);
         fail_q      <= (state_d == FAIL);
         coll_lock_q <= (state_q == COLLECT) && (state_d == LOCKED);
      end
   end

   // The latest lanes must already show a zero pointer when the freeze lands.
   always_ff @(posedge clk) begin
      if (nreset && coll_lock_q)
         assert (bus.skew_zero_i == latest_q);
   end

   assign bus.am_lite_lock_full_v_o = lock_full_q;
   assign bus.deskew_fail_o         = fail_q;
   assign bus.skew_span_o           = span_q;
   assign bus.latest_lane_o         = latest_q;
endmodule

// File: tb/tb_deskew_ctrl_rx.sv
// Directed bench for deskew_ctrl_rx: lock, re-verify, excess skew, span change,
// duplicate AM, lock drop and reset while locked.
module tb_deskew_ctrl_rx;
   localparam int LANE_N = 4;
   localparam int MAXN   = 27;
   localparam int WIN_W  = $clog2(MAXN + 1);

   logic clk;
   logic nreset;
   int   checks;
   int   failures;
   int   fail_cyc;
   int   lock_cyc;

   deskew_ctrl_rx_if #(.LANE_N(LANE_N), .WIN_W(WIN_W)) bus ();

   deskew_ctrl_rx #(.LANE_N(LANE_N), .MAX_SKEW_BLOCK_N(MAXN), .WIN_W(WIN_W)) dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Plays one AM period; lane k's AM arrives at relative cycle tk. Reports the
   // first cycle whose decision shows up as a fail pulse / lock_full.
   task automatic run_ams(input int t0, input int t1, input int t2, input int t3,
                          output int fc, output int lc);
      int last;
      last = t0;
      if (t1 > last) last = t1;
      if (t2 > last) last = t2;
      if (t3 > last) last = t3;
      fc = -1;
      lc = -1;
      for (int c = 0; c <= last; c++) begin
         bus.am_v_i = {t3 == c, t2 == c, t1 == c, t0 == c};
         tick();
         if (bus.deskew_fail_o && fc < 0) fc = c;
         if (bus.am_lite_lock_full_v_o && lc < 0) lc = c;
      end
      bus.am_v_i = '0;
   endtask

   task automatic chk_out(input string tag, input logic lf, input logic fl,
                          input int span, input logic [3:0] lat);
      chk({tag, "_lock"},   32'(bus.am_lite_lock_full_v_o), 32'(lf));
      chk({tag, "_fail"},   32'(bus.deskew_fail_o),         32'(fl));
      chk({tag, "_span"},   32'(bus.skew_span_o),           32'(span));
      chk({tag, "_latest"}, 32'(bus.latest_lane_o),         32'(lat));
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      nreset        = 1'b0;
      bus.am_lock_i = '0;
      bus.am_v_i    = '0;
      bus.skew_zero_i = '0;
      tick();
      tick();
      chk_out("reset", 1'b0, 1'b0, 0, 4'b0000);

      // Span 5 lock, lanes 2/3 last
      nreset        = 1'b1;
      bus.am_lock_i = 4'b1111;
      tick();
      bus.skew_zero_i = 4'b1100;
      run_ams(0, 2, 5, 5, fail_cyc, lock_cyc);
      chk("span5_lock_cyc", 32'(lock_cyc), 32'd5);
      chk_out("span5", 1'b1, 1'b0, 5, 4'b1100);

      // Same skew next period: stays locked
      run_ams(0, 2, 5, 5, fail_cyc, lock_cyc);
      chk("verify5_nofail", 32'(fail_cyc), 32'hffff_ffff);
      chk_out("verify5", 1'b1, 1'b0, 5, 4'b1100);

      // Skew grows to 6: fail one cycle after win hits 5
      run_ams(0, 6, 6, 6, fail_cyc, lock_cyc);
      chk("grow_fail_cyc", 32'(fail_cyc), 32'd5);
      chk_out("grow_after", 1'b0, 1'b0, 0, 4'b0000);
      tick();
      bus.skew_zero_i = 4'b1110;
      run_ams(0, 6, 6, 6, fail_cyc, lock_cyc);
      chk("relock6_cyc", 32'(lock_cyc), 32'd6);
      chk_out("relock6", 1'b1, 1'b0, 6, 4'b1110);

      // Lane 2 lock drop while LOCKED
      bus.am_lock_i = 4'b1011;
      tick();
      chk_out("lockdrop_locked", 1'b0, 1'b0, 0, 4'b0000);
      bus.am_lock_i = 4'b1111;
      tick();

      // Span 0, then same-cycle period keeps lock
      bus.skew_zero_i = 4'b1111;
      run_ams(0, 0, 0, 0, fail_cyc, lock_cyc);
      chk("span0_lock_cyc", 32'(lock_cyc), 32'd0);
      chk_out("span0", 1'b1, 1'b0, 0, 4'b1111);
      run_ams(0, 0, 0, 0, fail_cyc, lock_cyc);
      chk("span0_verify_nofail", 32'(fail_cyc), 32'hffff_ffff);
      chk_out("span0_verify", 1'b1, 1'b0, 0, 4'b1111);

      // Excess skew: lane 3 arrives 27 cycles after lane 0
      bus.am_lock_i = 4'b1011;
      tick();
      bus.am_lock_i = 4'b1111;
      tick();
      run_ams(0, 1, 2, 27, fail_cyc, lock_cyc);
      chk("excess_fail_cyc", 32'(fail_cyc), 32'd26);
      chk("excess_no_lock", 32'(lock_cyc), 32'hffff_ffff);
      tick();
      bus.skew_zero_i = 4'b1000;
      run_ams(0, 1, 1, 3, fail_cyc, lock_cyc);
      chk_out("excess_restart", 1'b1, 1'b0, 3, 4'b1000);

      // Duplicate AM on lane 1 before lane 2 arrives
      bus.am_lock_i = 4'b1011;
      tick();
      bus.am_lock_i = 4'b1111;
      tick();
      bus.am_v_i = 4'b0011;
      tick();
      bus.am_v_i = 4'b0010;
      tick();
      chk("dup_fail", 32'(bus.deskew_fail_o), 32'd1);
      chk("dup_lock", 32'(bus.am_lite_lock_full_v_o), 32'd0);
      bus.am_v_i = 4'b0000;
      tick();
      chk("dup_fail_single", 32'(bus.deskew_fail_o), 32'd0);
      tick();

      // Lock drop mid-COLLECT coinciding with an AM
      bus.am_v_i = 4'b0001;
      tick();
      bus.am_v_i    = 4'b0100;
      bus.am_lock_i = 4'b1011;
      tick();
      chk_out("lockdrop_collect", 1'b0, 1'b0, 0, 4'b0000);
      bus.am_v_i    = 4'b0000;
      bus.am_lock_i = 4'b1111;
      tick();
      bus.skew_zero_i = 4'b1000;
      run_ams(0, 0, 0, 1, fail_cyc, lock_cyc);
      chk_out("relock1", 1'b1, 1'b0, 1, 4'b1000);

      // Reset while LOCKED, then normal relock
      nreset = 1'b0;
      tick();
      chk_out("reset_locked", 1'b0, 1'b0, 0, 4'b0000);
      nreset = 1'b1;
      tick();
      bus.skew_zero_i = 4'b0001;
      run_ams(2, 0, 1, 0, fail_cyc, lock_cyc);
      chk("post_reset_lock_cyc", 32'(lock_cyc), 32'd2);
      chk_out("post_reset", 1'b1, 1'b0, 2, 4'b0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/deskew_ctrl_rx.md
Name: deskew_ctrl_rx

Overview:
- Multi-lane deskew controller. Sequences the per-lane deskew buffers of the PCS receive path.
- Collects the first alignment-marker (AM) arrival on every lane and measures the inter-lane skew span against buffer depth.
- Drives the shared all-lanes-AM-seen signal that freezes each lane's skew read pointer.
- Re-verifies skew on every subsequent AM period; on skew change, excess skew or lock loss, it drops the lock so the lanes re-deskew.

Parameters:
- LANE_N, 4, number of PCS lanes.
- MAX_SKEW_BLOCK_N, 27, per-lane deskew buffer depth in blocks; maximum legal span is MAX_SKEW_BLOCK_N-1.
- WIN_W, $clog2(MAX_SKEW_BLOCK_N+1), window counter width.

Ports:
- clk  in  1  clock; one block per lane per cycle.
- nreset  in  1  reset, synchronous, active-low.
- am_lock_i  in  LANE_N  per-lane AM lock status.
- am_v_i  in  LANE_N  per-lane AM block valid this cycle (raw, pre-deskew).
- skew_zero_i  in  LANE_N  per-lane skew-pointer-is-zero; debug/assertion only.
- am_lite_lock_full_v_o  out  1  all lanes deskewed; broadcast to every lane buffer.
- deskew_fail_o  out  1  single-cycle pulse on deskew failure.
- skew_span_o  out  WIN_W  measured span in blocks: last AM cycle minus first AM cycle.
- latest_lane_o  out  LANE_N  lanes whose AM arrived last at lock.

Behaviour:
- State machine: IDLE, COLLECT, LOCKED, VERIFY, FAIL. Registers: seen mask[LANE_N], win counter[WIN_W], span_q, latest_q.
- Reset: state=IDLE, mask=0, win=0. All outputs 0.
- Global rule: any am_lock_i bit low in COLLECT, LOCKED or VERIFY -> IDLE next cycle, mask cleared, no fail pulse. This rule has priority over all other transitions.
- IDLE:
  - am_v_i ignored.
  - All am_lock_i high -> COLLECT with mask=0.
- COLLECT:
  - m = mask | am_v_i.
  - Before the first AM, win is held at 0.
  - In the first-AM cycle, win=0; win increments every following cycle.
  - Duplicate AM (am_v_i & mask nonzero) -> FAIL.
  - m all-ones in the current cycle -> LOCKED; capture span_q=win and latest_q=am_v_i. This includes the span-0 case where all AMs arrive in one cycle.
  - m incomplete and win==MAX_SKEW_BLOCK_N-1 -> FAIL (span would exceed buffer depth).
- LOCKED:
  - Any am_v_i bit -> VERIFY with mask=am_v_i, win=0.
  - If am_v_i is all-ones in that cycle, evaluate the VERIFY completion check in the same cycle.
- VERIFY:
  - Same mask/win/duplicate rules as COLLECT.
  - On completion: win==span_q -> LOCKED; otherwise -> FAIL.
  - Incomplete and win==span_q -> FAIL.
- FAIL: lasts one cycle, then -> IDLE (which re-enters COLLECT if locks are still held).
- am_lite_lock_full_v_o is registered, high iff state is LOCKED or VERIFY. It rises exactly one cycle after the completing AM cycle, so the latest lane's pointer has already reset to 0 before the freeze. It falls the cycle after leaving VERIFY/LOCKED.
- deskew_fail_o = (state==FAIL), registered.
- skew_span_o and latest_lane_o:
  - Updated only on COLLECT completion and held through LOCKED/VERIFY.
  - Cleared on entry to IDLE.
- Simultaneous events: an AM and a lock drop in the same cycle -> lock drop wins.
- Assertion (sim only): in the first LOCKED cycle after COLLECT, skew_zero_i == latest_q.
- Latency summary: last AM at cycle t -> lock_full high at t+1. Fail condition at t -> deskew_fail_o at t+1, IDLE at t+2.

Test Plan:
- Locks high; AMs on lanes 0..3 at cycles 10,12,15,15 -> lock_full rises at 16, skew_span_o=5, latest_lane_o=4'b1100, skew_zero_i==4'b1100 at 16.
- All four AMs at cycle 10 -> lock_full at 11, span=0, latest=4'b1111. Next period all at one cycle -> stays LOCKED, no fail.
- Lane 3 AM arrives 27 cycles after lane 0 (first AM cycle 10) -> deskew_fail_o pulses at cycle 37, lock_full never rises, then COLLECT restarts.
- Locked with span 5; next period AMs spaced 6 apart -> fail pulse one cycle after win reaches 5 with mask incomplete, lock_full drops, relock at span 6 on the following period.
- Lane 1 AM twice in COLLECT before lane 2 arrives -> FAIL pulse. am_lock_i[2] dropped mid-COLLECT or while LOCKED -> IDLE, lock_full low next cycle, no fail pulse.
- nreset asserted while LOCKED -> next cycle all outputs 0, state IDLE. Release with locks high -> COLLECT, normal lock on next AM set.
